// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: pipe-register enables/flushes, load-use stalls,
// E-stage forwarding, vector-memory freeze and halt drain for the F/D/E/M/W datapath.
module pipe_hazard_ctrl #(
  parameter int RA_W = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            halt_d,
  input  logic [RA_W-1:0] ra1_d,
  input  logic [RA_W-1:0] ra2_d,
  input  logic [RA_W-1:0] ra1_e,
  input  logic [RA_W-1:0] ra2_e,
  input  logic [RA_W-1:0] wa3_e,
  input  logic            regwrite_e,
  input  logic            memtoreg_e,
  input  logic [RA_W-1:0] wa3_m,
  input  logic            regwrite_m,
  input  logic            memtoreg_m,
  input  logic            memwrite_m,
  input  logic [RA_W-1:0] wa3_w,
  input  logic            regwrite_w,
  input  logic            mem_ack,
  output logic            pc_en,
  output logic            cargar_fd,
  output logic            cargar_de,
  output logic            cargar_em,
  output logic            cargar_mw,
  output logic            flush_fd,
  output logic            flush_de,
  output logic [1:0]      fwd_a_e,
  output logic [1:0]      fwd_b_e,
  output logic            mem_req,
  output logic            busy,
  output logic            done
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RUN     = 3'd1;
  localparam logic [2:0] S_MEMWAIT = 3'd2;
  localparam logic [2:0] S_DRAIN   = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  logic [2:0] state, state_nxt;
  logic [1:0] drain_cnt, drain_nxt;
  logic       ret_drain, ret_nxt;
  logic       mem_start, load_use, do_run, do_drain;

  assign mem_start = memtoreg_m | memwrite_m;
  assign load_use  = regwrite_e & memtoreg_e &
                     ((wa3_e == ra1_d) | (wa3_e == ra2_d)) & ~halt_d;

  assign busy = (state == S_RUN) | (state == S_MEMWAIT) | (state == S_DRAIN);
  assign done = (state == S_DONE);

  // An acked MEMWAIT cycle replays as a RUN or DRAIN cycle, minus the memory-start check.
  always_comb begin
    pc_en     = 1'b0;
    cargar_fd = 1'b0;
    cargar_de = 1'b0;
    cargar_em = 1'b0;
    cargar_mw = 1'b0;
    flush_fd  = 1'b1;
    flush_de  = 1'b1;
    mem_req   = 1'b0;
    state_nxt = state;
    drain_nxt = drain_cnt;
    ret_nxt   = ret_drain;
    do_run    = 1'b0;
    do_drain  = 1'b0;

    case (state)
      S_RUN, S_DRAIN: begin
        if (mem_start) begin
          mem_req   = 1'b1;
          flush_fd  = 1'b0;
          flush_de  = 1'b0;
          ret_nxt   = (state == S_DRAIN);
          state_nxt = S_MEMWAIT;
        end else if (state == S_RUN) begin
          do_run = 1'b1;
        end else begin
          do_drain = 1'b1;
        end
      end
      S_MEMWAIT: begin
        mem_req  = 1'b1;
        flush_fd = 1'b0;
        flush_de = 1'b0;
        if (mem_ack) begin
          if (ret_drain) do_drain = 1'b1;
          else           do_run   = 1'b1;
        end
      end
      default: begin
        if (start) state_nxt = S_RUN;
      end
    endcase

    if (do_run) begin
      cargar_de = 1'b1;
      cargar_em = 1'b1;
      cargar_mw = 1'b1;
      flush_fd  = 1'b0;
      flush_de  = 1'b0;
      state_nxt = S_RUN;
      if (halt_d) begin
        cargar_fd = 1'b1;
        flush_fd  = 1'b1;
        drain_nxt = 2'd3;
        state_nxt = S_DRAIN;
      end else if (load_use) begin
        flush_de = 1'b1;
      end else begin
        pc_en     = 1'b1;
        cargar_fd = 1'b1;
      end
    end

    if (do_drain) begin
      cargar_fd = 1'b1;
      cargar_de = 1'b1;
      cargar_em = 1'b1;
      cargar_mw = 1'b1;
      flush_fd  = 1'b1;
      flush_de  = 1'b0;
      drain_nxt = drain_cnt - 2'd1;
      state_nxt = (drain_cnt == 2'd1) ? S_DONE : S_DRAIN;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      drain_cnt <= 2'd0;
      ret_drain <= 1'b0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_nxt;
      ret_drain <= ret_nxt;
    end
  end

  // M-stage ALU results take precedence over W; loads in M are not forwardable yet.
  always_comb begin
    fwd_a_e = 2'b00;
    fwd_b_e = 2'b00;
    if (regwrite_m & ~memtoreg_m & (wa3_m == ra1_e)) fwd_a_e = 2'b10;
    else if (regwrite_w & (wa3_w == ra1_e))          fwd_a_e = 2'b01;
    if (regwrite_m & ~memtoreg_m & (wa3_m == ra2_e)) fwd_b_e = 2'b10;
    else if (regwrite_w & (wa3_w == ra2_e))          fwd_b_e = 2'b01;
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench for pipe_hazard_ctrl; expected output vectors are queued by the
// driver and compared by an independent negedge monitor.
module tb_pipe_hazard_ctrl;

  localparam int RA_W = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            start, halt_d, regwrite_e, memtoreg_e, regwrite_m, memtoreg_m;
  logic            memwrite_m, regwrite_w, mem_ack;
  logic [RA_W-1:0] ra1_d, ra2_d, ra1_e, ra2_e, wa3_e, wa3_m, wa3_w;
  logic            pc_en, cargar_fd, cargar_de, cargar_em, cargar_mw, flush_fd, flush_de;
  logic [1:0]      fwd_a_e, fwd_b_e;
  logic            mem_req, busy, done;

  typedef struct {
    string      name;
    logic [13:0] val;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   checks = 0;
  int   errors = 0;
  logic [13:0] act;

  pipe_hazard_ctrl #(.RA_W(RA_W)) dut (
    .clk(clk), .reset(reset), .start(start), .halt_d(halt_d),
    .ra1_d(ra1_d), .ra2_d(ra2_d), .ra1_e(ra1_e), .ra2_e(ra2_e),
    .wa3_e(wa3_e), .regwrite_e(regwrite_e), .memtoreg_e(memtoreg_e),
    .wa3_m(wa3_m), .regwrite_m(regwrite_m), .memtoreg_m(memtoreg_m), .memwrite_m(memwrite_m),
    .wa3_w(wa3_w), .regwrite_w(regwrite_w), .mem_ack(mem_ack),
    .pc_en(pc_en), .cargar_fd(cargar_fd), .cargar_de(cargar_de), .cargar_em(cargar_em),
    .cargar_mw(cargar_mw), .flush_fd(flush_fd), .flush_de(flush_de),
    .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e), .mem_req(mem_req), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  assign act = {pc_en, cargar_fd, cargar_de, cargar_em, cargar_mw, flush_fd, flush_de,
                fwd_a_e, fwd_b_e, mem_req, busy, done};

  // Vector layout: pc_en, cargar fd/de/em/mw, flush fd/de, fwd_a, fwd_b, mem_req, busy, done
  function automatic logic [13:0] mk(input logic pc, input logic [3:0] c, input logic [1:0] fl,
                                     input logic [1:0] fa, input logic [1:0] fb,
                                     input logic mr, input logic bz, input logic dn);
    return {pc, c, fl, fa, fb, mr, bz, dn};
  endfunction

  always @(negedge clk) begin
    while (sb.size() > 0) begin
      cur = sb.pop_front();
      checks++;
      if (act !== cur.val) begin
        errors++;
        $display("[TB] FAIL %s: got %b expected %b", cur.name, act, cur.val);
      end
    end
  end

  // Moves to just after the next rising edge with all datapath inputs idle.
  task automatic apply_stimulus();
    @(posedge clk);
    #1;
    start = 0; halt_d = 0; mem_ack = 0;
    regwrite_e = 0; memtoreg_e = 0; regwrite_m = 0; memtoreg_m = 0; memwrite_m = 0;
    regwrite_w = 0;
    ra1_d = '0; ra2_d = '0; ra1_e = '0; ra2_e = '0; wa3_e = '0; wa3_m = '0; wa3_w = '0;
  endtask

  task automatic check_output(input string name, input logic [13:0] val);
    exp_t e;
    e.name = name;
    e.val  = val;
    sb.push_back(e);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [13:0] o_idle, o_run, o_lu, o_mem, o_drain, o_done;
    o_idle  = mk(1'b0, 4'b0000, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    o_run   = mk(1'b1, 4'b1111, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
    o_lu    = mk(1'b0, 4'b0111, 2'b01, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
    o_mem   = mk(1'b0, 4'b0000, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0);
    o_drain = mk(1'b0, 4'b1111, 2'b10, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
    o_done  = mk(1'b0, 4'b0000, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1);

    #2 reset = 1'b0;
    apply_stimulus();
    check_output("reset_outputs", o_idle);
    apply_stimulus();
    reset = 1'b1;
    check_output("idle_after_release", o_idle);

    // Forwarding while idle, so no memory start can interfere.
    apply_stimulus();
    ra1_e = 4'd5; wa3_m = 4'd5; regwrite_m = 1;
    check_output("fwd_a_m", o_idle | mk(0, 0, 0, 2'b10, 2'b00, 0, 0, 0));
    apply_stimulus();
    ra1_e = 4'd5; wa3_m = 4'd5; regwrite_m = 1; memtoreg_m = 1; wa3_w = 4'd5; regwrite_w = 1;
    check_output("fwd_a_w_load_in_m", o_idle | mk(0, 0, 0, 2'b01, 2'b00, 0, 0, 0));
    apply_stimulus();
    ra1_e = 4'd5; wa3_m = 4'd5; memtoreg_m = 1; wa3_w = 4'd5;
    check_output("fwd_a_none", o_idle);
    apply_stimulus();
    ra2_e = 4'd7; wa3_m = 4'd7; regwrite_m = 1; wa3_w = 4'd7; regwrite_w = 1;
    check_output("fwd_b_m_priority", o_idle | mk(0, 0, 0, 2'b00, 2'b10, 0, 0, 0));
    apply_stimulus();
    wa3_m = 4'd3; regwrite_m = 1; regwrite_w = 1;
    check_output("fwd_reg0_from_w", o_idle | mk(0, 0, 0, 2'b01, 2'b01, 0, 0, 0));

    apply_stimulus();
    start = 1;
    check_output("start_cycle", o_idle);
    apply_stimulus();
    check_output("first_run", o_run);

    apply_stimulus();
    regwrite_e = 1; memtoreg_e = 1; wa3_e = 4'd3; ra1_d = 4'd2; ra2_d = 4'd4;
    check_output("no_load_use_mismatch", o_run);
    apply_stimulus();
    regwrite_e = 1; memtoreg_e = 1; wa3_e = 4'd3; ra2_d = 4'd3;
    check_output("load_use_stall", o_lu);
    apply_stimulus();
    check_output("after_bubble", o_run);

    apply_stimulus();
    memwrite_m = 1;
    check_output("mem_start", o_mem);
    apply_stimulus();
    check_output("memwait_1", o_mem);
    apply_stimulus();
    check_output("memwait_2", o_mem);
    apply_stimulus();
    mem_ack = 1;
    check_output("memwait_ack", o_run | mk(0, 0, 0, 0, 0, 1'b1, 0, 0));
    apply_stimulus();
    check_output("after_ack_run", o_run);

    apply_stimulus();
    memtoreg_m = 1;
    check_output("load_start", o_mem);
    apply_stimulus();
    mem_ack = 1; regwrite_e = 1; memtoreg_e = 1; wa3_e = 4'd9; ra1_d = 4'd9;
    check_output("ack_with_load_use", o_lu | mk(0, 0, 0, 0, 0, 1'b1, 0, 0));
    apply_stimulus();
    check_output("after_ack_bubble", o_run);

    apply_stimulus();
    halt_d = 1; regwrite_e = 1; memtoreg_e = 1; wa3_e = 4'd3; ra1_d = 4'd3;
    check_output("halt_cycle", o_drain);
    apply_stimulus();
    check_output("drain_1", o_drain);
    apply_stimulus();
    check_output("drain_2", o_drain);
    apply_stimulus();
    check_output("drain_3", o_drain);
    apply_stimulus();
    mem_ack = 1;
    check_output("done", o_done);
    apply_stimulus();
    start = 1;
    check_output("done_restart", o_done);
    apply_stimulus();
    check_output("run_after_done", o_run);

    apply_stimulus();
    halt_d = 1;
    check_output("halt2_cycle", o_drain);
    apply_stimulus();
    check_output("halt2_drain_1", o_drain);
    apply_stimulus();
    memtoreg_m = 1;
    check_output("drain_mem_start", o_mem);
    apply_stimulus();
    check_output("drain_memwait", o_mem);
    apply_stimulus();
    mem_ack = 1;
    check_output("drain_ack", o_drain | mk(0, 0, 0, 0, 0, 1'b1, 0, 0));
    apply_stimulus();
    check_output("back_in_drain", o_drain);
    apply_stimulus();
    check_output("done2", o_done);

    apply_stimulus();
    start = 1;
    check_output("start3", o_done);
    apply_stimulus();
    check_output("run3", o_run);
    apply_stimulus();
    memwrite_m = 1;
    check_output("mem_start3", o_mem);
    apply_stimulus();
    check_output("memwait3", o_mem);
    apply_stimulus();
    reset = 1'b0;
    check_output("async_reset_in_memwait", o_idle);
    apply_stimulus();
    reset = 1'b1;
    check_output("idle_after_abort", o_idle);
    apply_stimulus();
    mem_ack = 1;
    check_output("idle_holds", o_idle);
    apply_stimulus();
    start = 1;
    check_output("restart_cycle", o_idle);
    apply_stimulus();
    check_output("run_after_restart", o_run);

    apply_stimulus();
    @(negedge clk);
    @(negedge clk);
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
